// File: rtl/instr_fetch_cache.sv
// Fetch front-end: PC, direct-mapped I-cache, refill and flush walk.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
`timescale 1ns/1ps
module instr_fetch_cache #(
   parameter int          LINES    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        flush_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
`ifdef ICACHE_STATS_EN
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o,
`endif
   output logic        busy_o
);
   localparam int IDX = $clog2(LINES);
   localparam int TW  = 32 - IDX - 2;

   typedef enum logic [1:0] {RUN, REFILL, FLUSH} state_t;

   state_t           state;
   logic [31:0]      pc;
   logic [LINES-1:0] valid;
   logic [TW-1:0]    tags [LINES];
   logic [31:0]      data [LINES];
   logic [IDX-1:0]   cnt;
   logic [IDX-1:0]   idx;
   logic [IDX-1:0]   fill_idx;
   logic [31:0]      rpc;
   logic             pend;
   logic             hit;
   logic             fill;

   // mem_addr_o doubles as the latched miss address
   assign idx      = pc[IDX+1:2];
   assign fill_idx = mem_addr_o[IDX+1:2];
   assign hit      = valid[idx] && (tags[idx] == pc[31:IDX+2]);
   assign rpc      = redirect_pc_i & ~32'h3;
   assign fill     = (state == REFILL) && mem_req_o && mem_ack_i;

   always_ff @(posedge clock) begin
      if (fill) begin
         data[fill_idx] <= mem_rdata_i;
         tags[fill_idx] <= mem_addr_o[31:IDX+2];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         pc         <= RESET_PC;
         valid      <= '0;
         cnt        <= '0;
         pend       <= 1'b0;
         if_valid_o <= 1'b0;
         if_instr_o <= '0;
         if_pc_o    <= '0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         busy_o     <= 1'b0;
`ifdef ICACHE_STATS_EN
         hit_count_o  <= '0;
         miss_count_o <= '0;
`endif
      end else begin
         unique case (state)
            RUN: begin
               if (redirect_i) begin
                  pc         <= rpc;
                  if_valid_o <= 1'b0;
               end else if (flush_i) begin
                  state      <= FLUSH;
                  cnt        <= '0;
                  if_valid_o <= 1'b0;
                  busy_o     <= 1'b1;
               end else if (!stall_i) begin
                  if (hit) begin
                     if_instr_o <= data[idx];
                     if_pc_o    <= pc;
                     if_valid_o <= 1'b1;
                     pc         <= pc + 32'd4;
`ifdef ICACHE_STATS_EN
                     hit_count_o <= hit_count_o + 32'd1;
`endif
                  end else begin
                     mem_req_o  <= 1'b1;
                     mem_addr_o <= pc;
                     if_valid_o <= 1'b0;
                     state      <= REFILL;
                     busy_o     <= 1'b1;
`ifdef ICACHE_STATS_EN
                     miss_count_o <= miss_count_o + 32'd1;
`endif
                  end
               end
            end
            REFILL: begin
               if (redirect_i)
                  pc <= rpc;
               if (flush_i)
                  pend <= 1'b1;
               // the request always completes, even after a redirect
               if (fill) begin
                  valid[fill_idx] <= 1'b1;
                  mem_req_o       <= 1'b0;
                  if (pend || flush_i) begin
                     state <= FLUSH;
                     cnt   <= '0;
                     pend  <= 1'b0;
                  end else begin
                     state  <= RUN;
                     busy_o <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (redirect_i)
                  pc <= rpc;
               valid[cnt] <= 1'b0;
               cnt        <= cnt + IDX'(1);
               if (cnt == IDX'(LINES - 1)) begin
                  state  <= RUN;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state  <= RUN;
               busy_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_cache.sv
// Scoreboard bench for instr_fetch_cache: refill latency, hits, stall,
// redirect during refill, flush walk and PC wrap.
`timescale 1ns/1ps
module tb_instr_fetch_cache;
   localparam int LAT = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        flush_i = 1'b0;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        busy_o;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;
`endif

   instr_fetch_cache #(.LINES(4), .RESET_PC(32'h40)) dut (
      .clock(clock),
      .reset(reset),
      .stall_i(stall_i),
      .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .flush_i(flush_i),
      .if_valid_o(if_valid_o),
      .if_instr_o(if_instr_o),
      .if_pc_o(if_pc_o),
      .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i),
`ifdef ICACHE_STATS_EN
      .hit_count_o(hit_count_o),
      .miss_count_o(miss_count_o),
`endif
      .busy_o(busy_o)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memf(logic [31:0] a);
      return (a == 32'h0) ? 32'h00500093 : (a ^ 32'hC0DE0000);
   endfunction

   logic [31:0] mq[$];
   logic [63:0] dq[$];
   int          dcyc[$];
   int          cyc = 0;
   int          ndeliv = 0;
   int          nreq = 0;
   int          req_cyc = 0;
   bit          pend_fill = 1'b0;
   bit          prev_req = 1'b0;
   logic [31:0] ea = '0;

   // monitor: refill requests and delivered instructions
   always @(posedge clock) begin
      logic        st;
      logic [63:0] e;
      st = stall_i;
      #1;
      cyc++;
      if (!reset) begin
         if (mem_req_o && !prev_req) begin
            nreq++;
            req_cyc = cyc;
            check("req_expected", 32'(mq.size() != 0), 32'd1);
            if (mq.size() != 0) begin
               ea = mq.pop_front();
               check("req_addr", mem_addr_o, ea);
            end
         end else if (mem_req_o && prev_req) begin
            check("req_hold", mem_addr_o, ea);
         end
         if (!mem_req_o && prev_req)
            pend_fill = 1'b1;
         if (if_valid_o && !st) begin
            ndeliv++;
            dcyc.push_back(cyc);
            check("deliv_expected", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
               e = dq.pop_front();
               check("deliv_pc", if_pc_o, e[63:32]);
               check("deliv_instr", if_instr_o, e[31:0]);
            end
            if (pend_fill)
               check("miss_penalty", 32'(cyc), 32'(req_cyc + LAT + 1));
            pend_fill = 1'b0;
         end
      end
      prev_req = mem_req_o;
   end

   // slow memory: ack sampled LAT cycles after the request rises
   int wcnt = 0;
   always @(negedge clock) begin
      if (mem_req_o && !mem_ack_i) begin
         if (wcnt == LAT - 1) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = memf(mem_addr_o);
            wcnt        = 0;
         end else begin
            wcnt++;
         end
      end else begin
         mem_ack_i   = 1'b0;
         mem_rdata_i = '0;
      end
   end

   task automatic run_n(int n);
      int tgt;
      tgt = ndeliv + n;
      stall_i = 1'b0;
      for (int k = 0; k < 400 && ndeliv < tgt; k++)
         @(negedge clock);
      stall_i = 1'b1;
      check("run_timeout", 32'(ndeliv >= tgt), 32'd1);
   endtask

   task automatic redir(logic [31:0] a);
      redirect_i    = 1'b1;
      redirect_pc_i = a;
      @(negedge clock);
      redirect_i = 1'b0;
      check("redir_valid", 32'(if_valid_o), 32'd0);
   endtask

   task automatic fetch(logic [31:0] a, bit miss);
      if (miss)
         mq.push_back(a);
      dq.push_back({a, memf(a)});
   endtask

   initial begin
      int b;
      int rc;
      int r0;
      int nb;
      repeat (3) @(negedge clock);
      check("rst_valid", 32'(if_valid_o), 32'd0);
      check("rst_req", 32'(mem_req_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_addr", mem_addr_o, 32'h0);
      fetch(32'h40, 1'b1);
      reset = 1'b0;
      @(posedge clock);
      #2;
      check("boot_req", 32'(mem_req_o), 32'd1);
      check("boot_addr", mem_addr_o, 32'h40);
      check("boot_busy", 32'(busy_o), 32'd1);
      run_n(1);

      redir(32'h0);
      fetch(32'h0, 1'b1);
      run_n(1);
`ifdef ICACHE_STATS_EN
      check("miss_count_cold", miss_count_o, 32'd2);
`endif
      for (int a = 4; a <= 12; a += 4)
         fetch(32'(a), 1'b1);
      run_n(3);

      b  = dcyc.size();
      r0 = nreq;
      redir(32'h0);
      rc = cyc;
      fetch(32'h0, 1'b0);
      fetch(32'h4, 1'b0);
      run_n(2);
      repeat (2) begin
         @(negedge clock);
         check("stall_pc", if_pc_o, 32'h4);
         check("stall_instr", if_instr_o, memf(32'h4));
         check("stall_valid", 32'(if_valid_o), 32'd1);
      end
      fetch(32'h8, 1'b0);
      fetch(32'hC, 1'b0);
      run_n(2);
      check("hit_first", 32'(dcyc[b]), 32'(rc + 1));
      check("hit_b2b", 32'(dcyc[b+1]), 32'(dcyc[b] + 1));
      check("stall_gap", 32'(dcyc[b+2]), 32'(dcyc[b+1] + 3));
      check("hit_resume", 32'(dcyc[b+3]), 32'(dcyc[b+2] + 1));
      check("hit_noreq", 32'(nreq), 32'(r0));

      redir(32'h18);
      fetch(32'h18, 1'b1);
      run_n(1);
      redir(32'h8);
      mq.push_back(32'h8);
      stall_i = 1'b0;
      @(negedge clock);
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h1E;
      @(negedge clock);
      redirect_i = 1'b0;
      check("rr_req", 32'(mem_req_o), 32'd1);
      check("rr_addr", mem_addr_o, 32'h8);
      check("rr_valid", 32'(if_valid_o), 32'd0);
      fetch(32'h1C, 1'b1);
      run_n(1);
      r0 = nreq;
      redir(32'h8);
      fetch(32'h8, 1'b0);
      run_n(1);
      check("line2_hit", 32'(nreq), 32'(r0));

      stall_i = 1'b0;
      flush_i = 1'b1;
      @(negedge clock);
      flush_i = 1'b0;
      stall_i = 1'b1;
      nb = 0;
      for (int k = 0; k < 8; k++) begin
         if (busy_o)
            nb++;
         @(negedge clock);
      end
      check("flush_busy", 32'(nb), 32'd4);
      r0 = nreq;
      redir(32'h0);
      fetch(32'h0, 1'b1);
      run_n(1);
      check("flush_miss", 32'(nreq), 32'(r0 + 1));

      r0 = nreq;
      redir(32'hFFFFFFFC);
      fetch(32'hFFFFFFFC, 1'b1);
      fetch(32'h0, 1'b0);
      run_n(2);
      check("wrap_noreq", 32'(nreq), 32'(r0 + 1));

`ifdef ICACHE_STATS_EN
      check("hit_count", hit_count_o, 32'd6);
      check("miss_count", miss_count_o, 32'd10);
`endif
      repeat (2) @(negedge clock);
      check("dq_empty", 32'(dq.size()), 32'd0);
      check("mq_empty", 32'(mq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
